// File: rtl/band_mixer.sv
// Eight-band weighted mixer: snapshots a set of band samples, multiply-accumulates
// them against per-band Q2.14 gains through one shared multiplier, then rounds and saturates.
module band_mixer #(
  parameter int DW    = 16,
  parameter int GW    = 16,
  parameter int GFRAC = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [DW-1:0] band0,
  input  logic signed [DW-1:0] band1,
  input  logic signed [DW-1:0] band2,
  input  logic signed [DW-1:0] band3,
  input  logic signed [DW-1:0] band4,
  input  logic signed [DW-1:0] band5,
  input  logic signed [DW-1:0] band6,
  input  logic signed [DW-1:0] band7,
  input  logic                 din_enable,
  input  logic                 gain_we,
  input  logic [2:0]           gain_addr,
  input  logic signed [GW-1:0] gain_data,
  output logic signed [DW-1:0] dataout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 sat,
  output logic                 overrun
);

  localparam int PW = DW + GW;  // full product width
  localparam int AW = PW + 3;   // headroom for eight products
  localparam int RW = AW + 1;   // one extra bit so the rounding bias cannot wrap

  localparam logic signed [GW-1:0] UNITY_GAIN = GW'(2 ** GFRAC);
  localparam logic signed [RW-1:0] ROUND_BIAS = RW'(2 ** (GFRAC - 1));
  localparam logic signed [RW-1:0] OUT_MAX    = RW'(2 ** (DW - 1) - 1);
  localparam logic signed [RW-1:0] OUT_MIN    = RW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DW-1:0] band_in  [8];
  logic signed [DW-1:0] snapshot [8];
  logic signed [GW-1:0] gain     [8];
  logic [2:0]           idx;
  logic signed [AW-1:0] acc;

  logic signed [PW-1:0] product;
  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  assign band_in = '{band0, band1, band2, band3, band4, band5, band6, band7};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (din_enable) state_next = MAC;
      MAC:     if (idx == 3'd7) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Sign-preserving size casts keep the multiply and the rounding fully signed.
  always_comb begin
    product = PW'(snapshot[idx]) * PW'(gain[idx]);
    acc_ext = RW'(acc);
    biased  = acc_ext + ROUND_BIAS;
    shifted = biased >>> GFRAC;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: snapshot and gain banks are small register arrays that must come out of
      // reset at known values (zero / unity), so they are reset like any other flop.
      for (int k = 0; k < 8; k++) begin
        snapshot[k] <= '0;
        gain[k]     <= UNITY_GAIN;
      end
      idx        <= '0;
      acc        <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking writes mean a MAC step reads the gain held before this edge;
      // a same-edge write only becomes visible from the next edge.
      if (gain_we) gain[gain_addr] <= gain_data;

      dout_valid <= (state == OUT);

      if (din_enable && state != IDLE) overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (din_enable) begin
            for (int k = 0; k < 8; k++) snapshot[k] <= band_in[k];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + AW'(product);
          idx <= idx + 3'd1;
        end
        OUT: begin
          if (shifted > OUT_MAX) begin
            dataout <= OUT_MAX[DW-1:0];
            sat     <= 1'b1;
          end else if (shifted < OUT_MIN) begin
            dataout <= OUT_MIN[DW-1:0];
            sat     <= 1'b1;
          end else begin
            dataout <= shifted[DW-1:0];
            sat     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: a reference model pushes expected mixes to a
// scoreboard queue at din_enable, popped and compared when dout_valid appears.
module tb_band_mixer;

  localparam int DW    = 16;
  localparam int GW    = 16;
  localparam int GFRAC = 14;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] band [8];
  logic                 din_enable;
  logic                 gain_we;
  logic [2:0]           gain_addr;
  logic signed [GW-1:0] gain_data;
  logic signed [DW-1:0] dataout;
  logic                 dout_valid;
  logic                 busy;
  logic                 sat;
  logic                 overrun;

  typedef struct {
    logic signed [DW-1:0] data;
    logic                 sat;
    int                   e0;
  } exp_t;

  exp_t                 sb[$];
  logic signed [GW-1:0] mgain [8];
  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   cyc      = 0;

  band_mixer #(.DW(DW), .GW(GW), .GFRAC(GFRAC)) dut (
    .clock      (clock),
    .reset      (reset),
    .band0      (band[0]),
    .band1      (band[1]),
    .band2      (band[2]),
    .band3      (band[3]),
    .band4      (band[4]),
    .band5      (band[5]),
    .band6      (band[6]),
    .band7      (band[7]),
    .din_enable (din_enable),
    .gain_we    (gain_we),
    .gain_addr  (gain_addr),
    .gain_data  (gain_data),
    .dataout    (dataout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .sat        (sat),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  function automatic exp_t model(input int e0);
    exp_t   e;
    longint sum = 0;
    for (int k = 0; k < 8; k++) sum += longint'(band[k]) * longint'(mgain[k]);
    sum = (sum + (longint'(1) <<< (GFRAC - 1))) >>> GFRAC;
    if (sum > 32767) begin
      e.data = 16'sd32767;
      e.sat  = 1'b1;
    end else if (sum < -32768) begin
      e.data = -16'sd32768;
      e.sat  = 1'b1;
    end else begin
      e.data = DW'(sum);
      e.sat  = 1'b0;
    end
    e.e0 = e0;
    return e;
  endfunction

  task automatic set_bands(input int v);
    for (int k = 0; k < 8; k++) band[k] = DW'(v);
  endtask

  task automatic write_gain(input int addr, input int val);
    gain_we   = 1'b1;
    gain_addr = 3'(addr);
    gain_data = GW'(val);
    tick();
    gain_we = 1'b0;
    mgain[addr] = GW'(val);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) mgain[k] = 16'sh4000;
  endtask

  task automatic start_mix();
    din_enable = 1'b1;
    sb.push_back(model(cyc + 1));
    tick();
    din_enable = 1'b0;
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int   budget = 20;
    while (!dout_valid && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (!dout_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: dout_valid=%0b required 1 within budget", name, dout_valid);
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: dout_valid=1 with empty scoreboard, required none", name);
    end else begin
      e = sb.pop_front();
      n_checks += 2;
      if (cyc - e.e0 !== 9) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d edges required 9", name, cyc - e.e0);
      end
      if (dataout !== e.data || sat !== e.sat) begin
        n_fail++;
        $display("FAIL %s_data: got %0d sat=%0b required %0d sat=%0b",
                 name, dataout, sat, e.data, e.sat);
      end
    end
  endtask

  task automatic check_no_valid(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dout_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL %s: got %0d dout_valid pulses required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    din_enable = 1'b1;
    gain_we    = 1'b1;
    gain_addr  = 3'd0;
    gain_data  = '0;
    set_bands(1000);
    tick();
    tick();
    din_enable = 1'b0;
    gain_we    = 1'b0;
    reset      = 1'b0;
    for (int k = 0; k < 8; k++) mgain[k] = 16'sh4000;
    n_checks++;
    if (dataout !== 16'sd0 || dout_valid !== 1'b0 || busy !== 1'b0 ||
        sat !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%0d valid=%0b busy=%0b sat=%0b ovr=%0b required all 0",
               dataout, dout_valid, busy, sat, overrun);
    end
  endtask

  task automatic test_basic();
    int bc = 0;
    int n  = 0;
    set_bands(1000);
    start_mix();
    while (!dout_valid && n < 20) begin
      if (busy) bc++;
      tick();
      n++;
    end
    n_checks++;
    if (bc !== 9) begin
      n_fail++;
      $display("FAIL basic_busy: got %0d busy cycles required 9", bc);
    end
    n_checks++;
    if (dataout !== 16'sd8000) begin
      n_fail++;
      $display("FAIL basic_8000: got %0d required 8000", dataout);
    end
    wait_result("basic");
    tick();
    n_checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse: got valid=%0b busy=%0b required 0 0", dout_valid, busy);
    end
  endtask

  task automatic test_saturation();
    set_bands(16000);
    start_mix();
    wait_result("sat_pos");
    repeat (3) tick();
    n_checks++;
    if (dataout !== 16'sd32767 || sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos_hold: got %0d sat=%0b required 32767 sat=1", dataout, sat);
    end
    set_bands(-32768);
    start_mix();
    wait_result("sat_neg");
    n_checks++;
    if (dataout !== -16'sd32768 || sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg_const: got %0d sat=%0b required -32768 sat=1", dataout, sat);
    end
  endtask

  task automatic test_rounding();
    for (int k = 0; k < 8; k++) write_gain(k, (k == 3) ? 32'sh2000 : 0);
    set_bands(0);
    band[3] = 16'sd101;
    start_mix();
    wait_result("round_pos");
    n_checks++;
    if (dataout !== 16'sd51 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL round_pos_const: got %0d sat=%0b required 51 sat=0", dataout, sat);
    end
    band[3] = -16'sd101;
    start_mix();
    wait_result("round_neg");
    n_checks++;
    if (dataout !== -16'sd50) begin
      n_fail++;
      $display("FAIL round_neg_const: got %0d required -50", dataout);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) write_gain(k, int'($urandom_range(0, 32'h7fff)) - 32'sh4000);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) band[k] = DW'($urandom);
      start_mix();
      wait_result("b2b");
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %0b required 0", overrun);
    end
    tick();
  endtask

  task automatic test_gain_hazard();
    for (int k = 0; k < 8; k++) write_gain(k, 32'sh4000);
    set_bands(1000);
    start_mix();                   // E0
    repeat (5) tick();             // E1..E5 read gains 0..4
    gain_we   = 1'b1;
    gain_addr = 3'd5;
    gain_data = 16'sh1000;
    tick();                        // E6 reads gain[5] while it is written
    gain_we  = 1'b0;
    mgain[5] = 16'sh1000;
    wait_result("hazard_old");
    start_mix();
    wait_result("hazard_new");
    n_checks++;
    if (dataout !== 16'sd7250) begin
      n_fail++;
      $display("FAIL hazard_new_const: got %0d required 7250", dataout);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    set_bands(1000);
    start_mix();                   // E0
    tick();                        // E1
    tick();                        // E2
    set_bands(2000);
    din_enable = 1'b1;
    tick();                        // E3: ignored
    din_enable = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %0b required 1", overrun);
    end
    wait_result("overrun_first");
    check_no_valid("overrun_extra_valid", 15);
    start_mix();
    wait_result("overrun_next");
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %0b required 1", overrun);
    end
    do_reset();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %0b required 0", overrun);
    end
  endtask

  task automatic test_reset_abort();
    write_gain(2, 0);
    write_gain(6, 32'sh7fff);
    set_bands(3000);
    din_enable = 1'b1;
    tick();                        // E0, no scoreboard entry: this set is aborted
    din_enable = 1'b0;
    repeat (3) tick();             // E1..E3
    reset = 1'b1;
    tick();                        // E4
    reset = 1'b0;
    for (int k = 0; k < 8; k++) mgain[k] = 16'sh4000;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %0b required 0", busy);
    end
    check_no_valid("abort_valid", 15);
    n_checks++;
    if (dataout !== 16'sd0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %0d sat=%0b required 0 sat=0", dataout, sat);
    end
    set_bands(1000);
    start_mix();
    wait_result("abort_after");
    n_checks++;
    if (dataout !== 16'sd8000) begin
      n_fail++;
      $display("FAIL abort_default_gains: got %0d required 8000", dataout);
    end
  endtask

  initial begin
    reset      = 1'b1;
    din_enable = 1'b0;
    gain_we    = 1'b0;
    gain_addr  = '0;
    gain_data  = '0;
    set_bands(0);
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_gain_hazard();
    test_overrun();
    test_reset_abort();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/band_mixer.md
BAND_MIXER -- requirements
Module: band_mixer

Interface
REQ-001 Parameter DW, 16, width of band samples and dataout.
REQ-002 Parameter GW, 16, gain word width (signed).
REQ-003 Parameter GFRAC, 14, gain fractional bits (Q2.14; 0x4000 = 1.0).
REQ-004 Single clock, synchronous active-high reset: clock in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-005 band0..band7  in  DW each  signed filter-bank band outputs, one per band.
REQ-006 din_enable  in  1  set of band samples valid this cycle; single-cycle pulse.
REQ-007 gain_we  in  1  gain register write strobe.
REQ-008 gain_addr  in  3  band index of the gain written.
REQ-009 gain_data  in  GW  signed gain value.
REQ-010 dataout  out  DW  signed mixed output sample, registered.
REQ-011 dout_valid  out  1  one-cycle pulse; dataout is new.
REQ-012 busy  out  1  high while a mix is in progress.
REQ-013 sat  out  1  saturation flag for the current dataout; updates with dout_valid.
REQ-014 overrun  out  1  sticky flag: din_enable arrived while busy; cleared only by reset.

Function
REQ-015 The block SHALL compute dataout = sat16(round(sum over k=0..7 of band_k * gain_k) >> GFRAC), with one shared multiplier time-multiplexed over the 8 bands.
REQ-016 The FSM SHALL have states IDLE, MAC, OUT: IDLE→MAC on din_enable; MAC→OUT after band index 7; OUT→IDLE unconditionally.
REQ-017 The block SHALL capture band0..band7 into a snapshot register bank, and clear the accumulator and band index to 0, at the edge where din_enable is sampled high in IDLE (edge E0).
REQ-018 At each edge E1..E8 in MAC, the block SHALL add snapshot_k * gain_k (k = index, 0..7) to the accumulator, then increment the index.
REQ-019 Products SHALL be full 2*DW... i.e. 32-bit signed; the accumulator SHALL be 35-bit signed; no intermediate overflow is possible.
REQ-020 At E9 (OUT), rounding SHALL be half-up: add 2^(GFRAC-1), then arithmetic shift right by GFRAC.
REQ-021 At E9, results above 32767 SHALL give dataout = 32767, results below -32768 SHALL give -32768, and sat SHALL be set to 1; otherwise sat SHALL be 0.
REQ-022 dataout and sat SHALL register at E9; dout_valid SHALL be high for exactly the one cycle following E9.
REQ-023 Latency SHALL be fixed: dout_valid rises 9 clock edges after the din_enable edge.
REQ-024 busy SHALL be high in MAC and OUT and low in IDLE.
REQ-025 A new set SHALL be accepted no earlier than the cycle in which dout_valid is high, which is IDLE.
REQ-026 din_enable while busy SHALL be ignored (no snapshot change) and SHALL set overrun.
REQ-027 gain_we SHALL write gain_data to gain[gain_addr] at the clock edge, in any state.
REQ-028 A MAC edge that reads gain k SHALL use the value held before that edge; a write at the same edge becomes visible from the next edge.
REQ-029 dataout and sat SHALL hold their values between dout_valid pulses.

Reset
REQ-030 Reset SHALL force: state IDLE, index 0, accumulator 0, snapshot 0, dataout 0, dout_valid 0, busy 0, sat 0, overrun 0, all gain[k] = 0x4000.
REQ-031 Reset SHALL take priority over din_enable and gain_we in the same cycle.
REQ-032 Reset mid-operation SHALL abort the mix; no dout_valid SHALL follow for the aborted set.

Verification
REQ-033 Reset, default gains, all bands = 1000, din_enable pulse -> dout_valid 9 edges later, dataout = 8000, sat = 0, busy high for 9 cycles.
REQ-034 All bands = 16000, default gains -> dataout = 32767, sat = 1; all bands = -32768 -> dataout = -32768, sat = 1.
REQ-035 Write gain[0..7] = 0 except gain[3] = 0x2000, band3 = 101, other bands 0 -> dataout = 51; band3 = -101 -> dataout = -50 (half-up rounding).
REQ-036 din_enable at E0 and again at E3 -> exactly one dout_valid (first set only), overrun = 1 and remains 1 until reset.
REQ-037 Reset asserted at E4 of a mix -> busy = 0 next cycle, no dout_valid, gains back to 0x4000; a following din_enable yields the correct result.
REQ-038 gain_we to gain[5] at the same edge that MAC reads index 5 -> old gain used for this sample, new gain used for the next sample.
